// File: rtl/double_frame_buffer.sv
// double_frame_buffer
//   Double-buffered pixel store between the plot renderer (writer) and the
//   VGA scan-out (reader). Scan-out always reads the front buffer; the
//   renderer always writes the back buffer. A swap request is held until the
//   display frame boundary (frame_end) so a frame never tears.
//
//   Optional feature macro: FRAME_BUFFER_CLEAR_EN
//     defined   : after every swap the new back buffer is zeroed, one pixel
//                 per cycle, and write_ready is low while that runs.
//     undefined : no hardware clear; write_ready is tied high.
//
// Ports
//   clk           system clock, all logic on posedge
//   rst           synchronous active-high reset
//   write_enable  write write_data to the back buffer at write_addr
//   write_addr    back-buffer pixel address
//   write_data    pixel value
//   write_ready   high when writes are accepted
//   read_addr     front-buffer pixel address from scan-out
//   read_data     registered front-buffer pixel (1-cycle latency)
//   frame_end     one-cycle strobe at end of the active display frame
//   swap_request  one-cycle strobe: renderer finished the back buffer
//   swap_pending  request latched, waiting for frame_end
//   swapped       one-cycle pulse in the cycle the front buffer changes
//   front_buffer  index of the buffer currently displayed
module double_frame_buffer #(
  parameter int HOR_ACTIVE_PIXELS = 640,
  parameter int VER_ACTIVE_PIXELS = 480,
  parameter int PIXEL_WIDTH       = 1,
  localparam int TOTAL_PIXELS     = HOR_ACTIVE_PIXELS * VER_ACTIVE_PIXELS,
  localparam int ADDR_WIDTH       = $clog2(TOTAL_PIXELS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   write_enable,
  input  logic [ADDR_WIDTH-1:0]  write_addr,
  input  logic [PIXEL_WIDTH-1:0] write_data,
  output logic                   write_ready,
  input  logic [ADDR_WIDTH-1:0]  read_addr,
  output logic [PIXEL_WIDTH-1:0] read_data,
  input  logic                   frame_end,
  input  logic                   swap_request,
  output logic                   swap_pending,
  output logic                   swapped,
  output logic                   front_buffer
);

  typedef enum logic [1:0] {
    IDLE,
    PENDING
`ifdef FRAME_BUFFER_CLEAR_EN
    , CLEAR
`endif
  } state_t;

  // State entered right after a swap edge.
`ifdef FRAME_BUFFER_CLEAR_EN
  localparam state_t POST_SWAP = CLEAR;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(TOTAL_PIXELS - 1);
`else
  localparam state_t POST_SWAP = IDLE;
`endif

  localparam logic [ADDR_WIDTH:0] TOTAL_EXT = (ADDR_WIDTH+1)'(TOTAL_PIXELS);

  state_t state, state_next;
  logic   front_next;
  logic   pending_next;
  logic   swapped_next;

  logic                   mem_we;
  logic [ADDR_WIDTH-1:0]  mem_addr;
  logic [PIXEL_WIDTH-1:0] mem_data;

  logic write_in_range;
  logic read_in_range;

`ifdef FRAME_BUFFER_CLEAR_EN
  logic [ADDR_WIDTH-1:0] clear_cnt, clear_cnt_next;
`endif

  logic [PIXEL_WIDTH-1:0] mem0 [TOTAL_PIXELS];
  logic [PIXEL_WIDTH-1:0] mem1 [TOTAL_PIXELS];

  // Extended by one bit so the compare stays meaningful when TOTAL_PIXELS
  // is an exact power of two.
  assign write_in_range = ({1'b0, write_addr} < TOTAL_EXT);
  assign read_in_range  = ({1'b0, read_addr}  < TOTAL_EXT);

`ifdef FRAME_BUFFER_CLEAR_EN
  assign write_ready = (state != CLEAR);
`else
  assign write_ready = 1'b1;
`endif

  // State and control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      front_buffer <= 1'b0;
      swap_pending <= 1'b0;
      swapped      <= 1'b0;
`ifdef FRAME_BUFFER_CLEAR_EN
      clear_cnt    <= '0;
`endif
    end else begin
      state        <= state_next;
      front_buffer <= front_next;
      swap_pending <= pending_next;
      swapped      <= swapped_next;
`ifdef FRAME_BUFFER_CLEAR_EN
      clear_cnt    <= clear_cnt_next;
`endif
    end
  end

  // Next-state, swap control and back-buffer write port selection.
  always_comb begin
    state_next   = state;
    front_next   = front_buffer;
    pending_next = swap_pending;
    swapped_next = 1'b0;
    mem_we       = write_enable && write_ready && write_in_range;
    mem_addr     = write_addr;
    mem_data     = write_data;
`ifdef FRAME_BUFFER_CLEAR_EN
    clear_cnt_next = clear_cnt;
`endif

    case (state)
      IDLE: begin
        if (swap_request) begin
          if (frame_end) begin
            // Request on the frame boundary itself: swap without pending.
            front_next   = ~front_buffer;
            swapped_next = 1'b1;
            state_next   = POST_SWAP;
          end else begin
            pending_next = 1'b1;
            state_next   = PENDING;
          end
        end
      end

      PENDING: begin
        // Extra swap_request pulses here are absorbed.
        if (frame_end) begin
          front_next   = ~front_buffer;
          swapped_next = 1'b1;
          pending_next = 1'b0;
          state_next   = POST_SWAP;
        end
      end

`ifdef FRAME_BUFFER_CLEAR_EN
      CLEAR: begin
        // Renderer writes are blocked (write_ready low); the write port is
        // owned by the clear counter. frame_end is ignored here.
        mem_we   = 1'b1;
        mem_addr = clear_cnt;
        mem_data = '0;
        if (swap_request) begin
          pending_next = 1'b1;
        end
        if (clear_cnt == LAST_ADDR) begin
          clear_cnt_next = '0;
          state_next     = (swap_pending || swap_request) ? PENDING : IDLE;
        end else begin
          clear_cnt_next = clear_cnt + 1'b1;
        end
      end
`endif

      default: begin
        state_next = IDLE;
      end
    endcase

    // Nothing is written on a reset edge, so an aborted clear stops cleanly.
    if (rst) begin
      mem_we = 1'b0;
    end
  end

  // Back-buffer write: always the buffer not being displayed.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      if (front_buffer) begin
        mem0[mem_addr] <= mem_data;
      end else begin
        mem1[mem_addr] <= mem_data;
      end
    end
  end

  // Front-buffer read, registered. On the swap edge front_buffer still holds
  // the old index, so that read returns old-front data.
  always_ff @(posedge clk) begin
    if (rst) begin
      read_data <= '0;
    end else if (!read_in_range) begin
      read_data <= '0;
    end else if (front_buffer) begin
      read_data <= mem1[read_addr];
    end else begin
      read_data <= mem0[read_addr];
    end
  end

endmodule

// File: tb/tb_double_frame_buffer.sv
// tb_double_frame_buffer
//   Directed, table-driven bench for double_frame_buffer on a 4x4 frame.
//   Each record drives one cycle of inputs and lists the outputs expected
//   just after the following rising edge. Builds with or without
//   FRAME_BUFFER_CLEAR_EN; the clear-specific sequences are selected by the
//   same macro.
module tb_double_frame_buffer;

`ifdef FRAME_BUFFER_CLEAR_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       write_enable;
  logic [3:0] write_addr;
  logic       write_data;
  logic       write_ready;
  logic [3:0] read_addr;
  logic       read_data;
  logic       frame_end;
  logic       swap_request;
  logic       swap_pending;
  logic       swapped;
  logic       front_buffer;

  double_frame_buffer #(
    .HOR_ACTIVE_PIXELS(4),
    .VER_ACTIVE_PIXELS(4),
    .PIXEL_WIDTH(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .write_enable(write_enable),
    .write_addr(write_addr),
    .write_data(write_data),
    .write_ready(write_ready),
    .read_addr(read_addr),
    .read_data(read_data),
    .frame_end(frame_end),
    .swap_request(swap_request),
    .swap_pending(swap_pending),
    .swapped(swapped),
    .front_buffer(front_buffer)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       we;
    logic [3:0] wa;
    logic       wd;
    logic [3:0] ra;
    logic       fe;
    logic       sr;
    logic       chk_rd;
    logic       rd;
    logic       front;
    logic       pend;
    logic       swp;
    logic       rdy;
  } vec_t;

  vec_t vecs[$];
  int   n_pass  = 0;
  int   n_total = 0;

  function automatic void add(input logic r, input logic we, input int wa,
                              input logic wd, input int ra, input logic fe,
                              input logic sr, input logic chk_rd,
                              input logic rd, input logic front,
                              input logic pend, input logic swp,
                              input logic rdy);
    vec_t v;
    v.rst = r;    v.we = we;         v.wa = 4'(wa);  v.wd = wd;
    v.ra = 4'(ra); v.fe = fe;        v.sr = sr;      v.chk_rd = chk_rd;
    v.rd = rd;    v.front = front;   v.pend = pend;  v.swp = swp;
    v.rdy = rdy;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input int idx, input logic act,
                       input logic exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s vec %0d: got %b expected %b", name, idx, act, exp);
    end
  endtask

  initial begin
    // Reset, then fill both buffers with 0 using two same-cycle swaps.
    add(1,0,0,0,0,0,0, 1,0, 0,0,0,1);
    add(1,0,0,0,0,0,0, 1,0, 0,0,0,1);
    for (int i = 0; i < 16; i++) add(0,1,i,0,0,0,0, 0,0, 0,0,0,1);
    add(0,0,0,0,0,1,1, 0,0, 1,0,1,!CLR);
    for (int k = 1; k <= 16; k++)
      add(0,1,k-1,0,0,0,0, 0,0, 1,0,0, CLR ? (k == 16) : 1'b1);
    add(0,0,0,0,0,1,1, 0,0, 0,0,1,!CLR);
    for (int k = 1; k <= 16; k++)
      add(0,1,k-1,0,0,0,0, 0,0, 0,0,0, CLR ? (k == 16) : 1'b1);

    // Write 1 to back 0..7; reads of front 0..7 stay 0.
    for (int i = 0; i < 8; i++) add(0,1,i,1,i,0,0, 1,0, 0,0,0,1);
    // Request, a second absorbed request, then frame_end 5 cycles later.
    add(0,0,0,0,0,0,1, 1,0, 0,1,0,1);
    add(0,0,0,0,1,0,1, 1,0, 0,1,0,1);
    for (int i = 2; i <= 4; i++) add(0,0,0,0,i,0,0, 1,0, 0,1,0,1);
    // Swap edge: read still returns old front.
    add(0,0,0,0,0,1,0, 1,0, 1,0,1,!CLR);
    // New front shows the 1s; writes to back 8..15 (dropped while clearing).
    for (int i = 0; i < 8; i++) add(0,1,8+i,1,i,0,0, 1,1, 1,0,0,!CLR);
    for (int i = 0; i < 7; i++) add(0,0,0,0,8+i,0,0, 1,0, 1,0,0,!CLR);
    add(0,0,0,0,15,0,0, 1,0, 1,0,0,1);
    // Same-cycle request + frame_end: swap with no pending.
    add(0,0,0,0,8,1,1, 1,0, 0,0,1,!CLR);
    for (int i = 0; i < 8; i++) add(0,0,0,0,8+i,0,0, 1,!CLR, 0,0,0,!CLR);

`ifdef FRAME_BUFFER_CLEAR_EN
    // Request and frame_end during clear: latched, no swap.
    add(0,0,0,0,0,0,1, 1,0, 0,1,0,0);
    add(0,0,0,0,0,1,0, 1,0, 0,1,0,0);
    for (int i = 0; i < 5; i++) add(0,1,i,1,0,0,0, 1,0, 0,1,0,0);
    add(0,0,0,0,0,0,0, 1,0, 0,1,0,1);
    // First frame_end after the clear performs the swap.
    add(0,0,0,0,0,1,0, 1,0, 1,0,1,0);
    // Buffer 1 was cleared by hardware: former 1s now read 0.
    for (int i = 0; i < 8; i++) add(0,0,0,0,i,0,0, 1,0, 1,0,0,0);
    // Reset mid-clear.
    add(1,0,0,0,0,0,0, 1,0, 0,0,0,1);
    add(0,0,0,0,0,0,0, 1,0, 0,0,0,1);
`else
    // Reset while a swap is pending.
    add(0,0,0,0,0,0,1, 1,0, 0,1,0,1);
    add(1,0,0,0,0,0,0, 1,0, 0,0,0,1);
    add(0,0,0,0,0,0,0, 1,0, 0,0,0,1);
`endif

    rst = 1'b1; write_enable = 1'b0; write_addr = '0; write_data = 1'b0;
    read_addr = '0; frame_end = 1'b0; swap_request = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst          = vecs[i].rst;
      write_enable = vecs[i].we;
      write_addr   = vecs[i].wa;
      write_data   = vecs[i].wd;
      read_addr    = vecs[i].ra;
      frame_end    = vecs[i].fe;
      swap_request = vecs[i].sr;
      @(posedge clk);
      #1;
      if (vecs[i].chk_rd) check("read_data", i, read_data, vecs[i].rd);
      check("front_buffer", i, front_buffer, vecs[i].front);
      check("swap_pending", i, swap_pending, vecs[i].pend);
      check("swapped", i, swapped, vecs[i].swp);
      check("write_ready", i, write_ready, vecs[i].rdy);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
